// File: rtl/olivia_pkg.sv
// Shared defaults and the prefetch buffer entry type for the Olivia fetch front end.
package olivia_pkg;

    localparam int unsigned DEF_ADDR_W  = 64;
    localparam int unsigned DEF_INSTR_W = 32;
    localparam int unsigned DEF_PC_STEP = 4;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: power-of-two depth, synchronous flush, head forced to zero when empty.
module fetch_fifo
    import olivia_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  entry_t           push_data_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output logic             head_valid_o,
    output entry_t           head_o
);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop_s;
    logic             do_push_s;

    assign do_pop_s  = pop_i & (count_q != {CNT_W{1'b0}});
    assign do_push_s = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop_s);
    assign count_o   = count_q;

    // Pointer and occupancy next state; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Head presentation, zeroed when nothing is buffered.
    always_comb begin
        if (count_q != {CNT_W{1'b0}}) begin
            head_valid_o = 1'b1;
            head_o       = mem_q[rd_ptr_q];
        end else begin
            head_valid_o = 1'b0;
            head_o       = '0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Credit-controlled instruction fetch engine: PC sequencing, one in-flight request
// to a one-cycle memory, and a prefetch FIFO feeding decode.
module fetch_unit
    import olivia_pkg::*;
#(
    parameter int unsigned        ADDR_W   = DEF_ADDR_W,
    parameter int unsigned        INSTR_W  = DEF_INSTR_W,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        PC_STEP  = DEF_PC_STEP
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [ADDR_W-1:0]  inst_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned CRD_W = CNT_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0]  count_s;
    logic [CRD_W-1:0]  credit_s;
    logic              pop_s;
    logic              push_s;
    entry_t            push_data_s;
    entry_t            head_s;

    // Slots committed after this cycle: buffered + returning - leaving. Never negative,
    // since a pop needs a buffered entry; the extra bit keeps it from wrapping.
    assign pop_s       = inst_valid & inst_ready;
    assign credit_s    = CRD_W'(count_s) + CRD_W'(inflight_q) - CRD_W'(pop_s);
    assign imem_req    = rst & ~redirect_valid & (credit_s < CRD_W'(DEPTH));
    assign imem_addr   = fetch_pc_q;
    assign push_s      = inflight_q & ~redirect_valid;
    assign push_data_s = '{pc: inflight_pc_q, instr: imem_rdata};
    assign inst_data   = head_s.instr;
    assign inst_pc     = head_s.pc;

    // PC and in-flight next state; a redirect squashes the returning response.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            inflight_d = 1'b0;
        end else if (imem_req) begin
            fetch_pc_d    = fetch_pc_q + ADDR_W'(PC_STEP);
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
        end else begin
            inflight_d = 1'b0;
        end
    end

    // PC and in-flight tracking registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= {ADDR_W{1'b0}};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst),
        .flush_i      (redirect_valid),
        .push_i       (push_s),
        .push_data_i  (push_data_s),
        .pop_i        (pop_s),
        .count_o      (count_s),
        .head_valid_o (inst_valid),
        .head_o       (head_s)
    );

endmodule
